// File: rtl/prog_patt_det_if.sv
// Bit-stream and configuration bundle for the programmable pattern detector.
// master = bit source / config host, slave = detector.
interface prog_patt_det_if #(
   parameter int MAX_BITS = 8,
   parameter int CNT_W    = 8,
   parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
   logic                valid;
   logic                data;
   logic                cfg_load;
   logic [MAX_BITS-1:0] cfg_pattern;
   logic [LEN_W-1:0]    cfg_len;
   logic                cfg_overlap;
   logic                detect;
   logic [CNT_W-1:0]    match_cnt;
   logic [1:0]          state;
   logic                cfg_err;

   modport master (
      output valid, data, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
      input  detect, match_cnt, state, cfg_err
   );

   modport slave (
      input  valid, data, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
      output detect, match_cnt, state, cfg_err
   );
endinterface

// File: rtl/prog_patt_det.sv
// Programmable serial pattern detector: run-time pattern/length/overlap,
// registered one-cycle detect pulse, saturating match counter, config-error pulse.
module prog_patt_det #(
   parameter int MAX_BITS = 8,
   parameter int CNT_W    = 8,
   parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   prog_patt_det_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } state_t;

   state_t              st_q, st_n;
   logic [MAX_BITS-1:0] sr_q, sr_n;
   logic [MAX_BITS-1:0] pat_q, pat_n;
   logic [LEN_W-1:0]    len_q, len_n;
   logic                ovl_q, ovl_n;
   logic [LEN_W-1:0]    fill_q, fill_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic                det_q, det_n;
   logic                err_q, err_n;

   logic [MAX_BITS-1:0] sr_shift;
   logic [MAX_BITS-1:0] mask;
   logic [LEN_W-1:0]    fill_inc;
   logic                cfg_legal;
   logic                hit;

   // Datapath helpers: shifted history, length mask and match decision.
   always_comb begin
      mask      = '0;
      sr_shift  = {sr_q[MAX_BITS-2:0], bus.data};
      cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_BITS));
      fill_inc  = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
      for (int unsigned i = 0; i < MAX_BITS; i++)
         mask[i] = (i < 32'(len_q));
      hit = (((sr_shift ^ pat_q) & mask) == '0) && (fill_inc >= len_q);
   end

   // Next-state logic; a config load takes priority over the data bit on the same edge.
   always_comb begin
      st_n   = st_q;
      sr_n   = sr_q;
      pat_n  = pat_q;
      len_n  = len_q;
      ovl_n  = ovl_q;
      fill_n = fill_q;
      cnt_n  = cnt_q;
      det_n  = 1'b0;
      err_n  = 1'b0;
      if (bus.cfg_load) begin
         if (cfg_legal) begin
            pat_n  = bus.cfg_pattern;
            len_n  = bus.cfg_len;
            ovl_n  = bus.cfg_overlap;
            sr_n   = '0;
            fill_n = '0;
            cnt_n  = '0;
            st_n   = FILL;
         end else begin
            err_n = 1'b1;
         end
      end else if (bus.valid && (st_q != IDLE)) begin
         sr_n   = sr_shift;
         fill_n = fill_inc;
         if (hit) begin
            det_n = 1'b1;
            if (cnt_q != '1)
               cnt_n = cnt_q + CNT_W'(1);
            // Non-overlapping: restart collection so the next match needs len fresh bits.
            if (ovl_q) begin
               st_n = HUNT;
            end else begin
               st_n   = FILL;
               fill_n = '0;
               sr_n   = '0;
            end
         end else if (fill_inc >= len_q) begin
            st_n = HUNT;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q   <= IDLE;
         sr_q   <= '0;
         pat_q  <= '0;
         len_q  <= '0;
         ovl_q  <= 1'b0;
         fill_q <= '0;
         cnt_q  <= '0;
         det_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_n;
         sr_q   <= sr_n;
         pat_q  <= pat_n;
         len_q  <= len_n;
         ovl_q  <= ovl_n;
         fill_q <= fill_n;
         cnt_q  <= cnt_n;
         det_q  <= det_n;
         err_q  <= err_n;
      end
   end

   assign bus.detect    = det_q;
   assign bus.match_cnt = cnt_q;
   assign bus.state     = st_q;
   assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_prog_patt_det.sv
// Directed bench for prog_patt_det: vector table plus hand-written corner sequences.
module tb_prog_patt_det;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   prog_patt_det_if #(.MAX_BITS(8), .CNT_W(8)) b1 ();
   prog_patt_det_if #(.MAX_BITS(8), .CNT_W(2)) b2 ();

   prog_patt_det #(.MAX_BITS(8), .CNT_W(8)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
   prog_patt_det #(.MAX_BITS(8), .CNT_W(2)) dut2 (.clk(clk), .rstn(rstn), .bus(b2));

   typedef struct {
      logic       ld;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       vld;
      logic       dat;
      logic       det;
      logic [7:0] cnt;
      logic [1:0] st;
      logic       err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t L(input logic [7:0] p, input logic [3:0] n, input logic o,
                              input logic [7:0] c, input logic [1:0] s, input logic e);
      vec_t r;
      r.ld = 1'b1; r.pat = p; r.len = n; r.ovl = o; r.vld = 1'b0; r.dat = 1'b0;
      r.det = 1'b0; r.cnt = c; r.st = s; r.err = e;
      return r;
   endfunction

   function automatic vec_t B(input logic v, input logic d, input logic dt,
                              input logic [7:0] c, input logic [1:0] s);
      vec_t r;
      r.ld = 1'b0; r.pat = '0; r.len = '0; r.ovl = 1'b0; r.vld = v; r.dat = d;
      r.det = dt; r.cnt = c; r.st = s; r.err = 1'b0;
      return r;
   endfunction

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic ld, input logic [7:0] p, input logic [3:0] n,
                         input logic o, input logic v, input logic d);
      b1.cfg_load = ld; b1.cfg_pattern = p; b1.cfg_len = n; b1.cfg_overlap = o;
      b1.valid = v; b1.data = d;
   endtask

   initial begin
      logic [7:0] a5;
      drive1(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      b2.cfg_load = 1'b0; b2.cfg_pattern = '0; b2.cfg_len = '0; b2.cfg_overlap = 1'b0;
      b2.valid = 1'b0; b2.data = 1'b0;

      // Overlap, pattern 1011
      tbl.push_back(L(8'h0B, 4'd4, 1'b1, 8'd0, 2'd1, 1'b0));
      tbl.push_back(B(1,1,0,0,1)); tbl.push_back(B(1,0,0,0,1)); tbl.push_back(B(1,1,0,0,1));
      tbl.push_back(B(1,1,1,1,2)); tbl.push_back(B(1,0,0,1,2)); tbl.push_back(B(1,1,0,1,2));
      tbl.push_back(B(1,1,1,2,2)); tbl.push_back(B(0,1,0,2,2));
      // Non-overlap, pattern 1011, then 1,0,1,1 appended
      tbl.push_back(L(8'h0B, 4'd4, 1'b0, 8'd0, 2'd1, 1'b0));
      tbl.push_back(B(1,1,0,0,1)); tbl.push_back(B(1,0,0,0,1)); tbl.push_back(B(1,1,0,0,1));
      tbl.push_back(B(1,1,1,1,1)); tbl.push_back(B(1,0,0,1,1)); tbl.push_back(B(1,1,0,1,1));
      tbl.push_back(B(1,1,0,1,1)); tbl.push_back(B(1,1,0,1,2)); tbl.push_back(B(1,0,0,1,2));
      tbl.push_back(B(1,1,0,1,2)); tbl.push_back(B(1,1,1,2,1));
      // Pattern 10110 with a valid=0 gap
      tbl.push_back(L(8'h16, 4'd5, 1'b1, 8'd0, 2'd1, 1'b0));
      tbl.push_back(B(1,1,0,0,1)); tbl.push_back(B(1,0,0,0,1)); tbl.push_back(B(1,1,0,0,1));
      tbl.push_back(B(1,1,0,0,1)); tbl.push_back(B(0,0,0,0,1)); tbl.push_back(B(0,1,0,0,1));
      tbl.push_back(B(0,0,0,0,1)); tbl.push_back(B(1,0,1,1,2));
      // Illegal loads in HUNT leave the 10110 config in place
      tbl.push_back(L(8'hFF, 4'd0, 1'b0, 8'd1, 2'd2, 1'b1)); tbl.push_back(B(0,0,0,1,2));
      tbl.push_back(L(8'hFF, 4'd9, 1'b0, 8'd1, 2'd2, 1'b1)); tbl.push_back(B(0,0,0,1,2));
      tbl.push_back(B(1,1,0,1,2)); tbl.push_back(B(1,0,0,1,2)); tbl.push_back(B(1,1,0,1,2));
      tbl.push_back(B(1,1,0,1,2)); tbl.push_back(B(1,0,1,2,2));

      // Reset state
      #12;
      check("rst_state", 0, 32'(b1.state), 32'd0);
      check("rst_detect", 0, 32'(b1.detect), 32'd0);
      check("rst_cnt", 0, 32'(b1.match_cnt), 32'd0);
      check("rst_err", 0, 32'(b1.cfg_err), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // IDLE ignores data
      drive1(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      tick(); tick();
      check("idle_hold_state", 0, 32'(b1.state), 32'd0);
      check("idle_hold_det", 0, 32'(b1.detect), 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive1(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].vld, tbl[i].dat);
         tick();
         check("tbl_detect", i, 32'(b1.detect), 32'(tbl[i].det));
         check("tbl_cnt", i, 32'(b1.match_cnt), 32'(tbl[i].cnt));
         check("tbl_state", i, 32'(b1.state), 32'(tbl[i].st));
         check("tbl_err", i, 32'(b1.cfg_err), 32'(tbl[i].err));
      end
      drive1(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

      // CNT_W=2 saturation, len=1 non-overlap
      b2.cfg_load = 1'b1; b2.cfg_pattern = 8'h01; b2.cfg_len = 4'd1; b2.cfg_overlap = 1'b0;
      tick();
      check("sat_load_state", 0, 32'(b2.state), 32'd1);
      b2.cfg_load = 1'b0; b2.valid = 1'b1; b2.data = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("sat_detect", i, 32'(b2.detect), 32'd1);
         check("sat_cnt", i, 32'(b2.match_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
         check("sat_state", i, 32'(b2.state), 32'd1);
      end
      b2.data = 1'b0;
      tick();
      check("sat_nomatch_det", 0, 32'(b2.detect), 32'd0);
      check("sat_nomatch_cnt", 0, 32'(b2.match_cnt), 32'd3);
      b2.valid = 1'b0;

      // Async reset mid-pattern
      drive1(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      tick();
      drive1(1'b0, '0, '0, 1'b0, 1'b1, 1'b1); tick();
      b1.data = 1'b0; tick();
      b1.data = 1'b1; tick();
      check("pre_rst_state", 0, 32'(b1.state), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("async_rst_state", 0, 32'(b1.state), 32'd0);
      check("async_rst_det", 0, 32'(b1.detect), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      check("post_rst_idle", 0, 32'(b1.state), 32'd0);
      drive1(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      tick();
      drive1(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reload_det", i, 32'(b1.detect), 32'd0);
      end
      check("reload_state", 0, 32'(b1.state), 32'd1);
      check("reload_cnt", 0, 32'(b1.match_cnt), 32'd0);

      // Full-width pattern A5
      drive1(1'b1, 8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
      tick();
      a5 = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         drive1(1'b0, '0, '0, 1'b0, 1'b1, a5[7 - i]);
         tick();
         check("a5_detect", i, 32'(b1.detect), (i == 7) ? 32'd1 : 32'd0);
      end
      check("a5_cnt", 0, 32'(b1.match_cnt), 32'd1);
      check("a5_state", 0, 32'(b1.state), 32'd2);
      drive1(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      check("a5_pulse_end", 0, 32'(b1.detect), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
